// File: rtl/delay_replay_if.sv
// delay_replay_if: control, digit and status bundle between the replay counter and its controller
//   master: drives load/start/abort/tick and d1..d4, observes qq1..qq4/busy/done/error_bad_bcd
//   slave:  the counter side
interface delay_replay_if;
  logic load, start, abort, tick;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] qq1, qq2, qq3, qq4;
  logic busy, done, error_bad_bcd;
  modport master (
    output load, start, abort, tick, d1, d2, d3, d4,
    input  qq1, qq2, qq3, qq4, busy, done, error_bad_bcd
  );
  modport slave (
    input  load, start, abort, tick, d1, d2, d3, d4,
    output qq1, qq2, qq3, qq4, busy, done, error_bad_bcd
  );
endinterface

// File: rtl/delay_replay.sv
// delay_replay: four-digit BCD down-counter replaying a recorded delay, pulsing done at 0000
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : load/start/abort/tick and d1..d4 in; qq1..qq4 remaining count, busy, done, error_bad_bcd out
//   AUTO_RELOAD: 1 reloads the shadow value after each done and keeps running until abort
module delay_replay #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic clk,
  input logic rst_n,
  delay_replay_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_t;
  state_t state, state_n;
  logic [3:0][3:0] cnt, cnt_n, shadow, shadow_n, din, dec;
  logic bad, borrow, err_q, err_n, busy_q, done_q;
  assign din = {bus.d4, bus.d3, bus.d2, bus.d1};
  assign bad = (bus.d1 > 4'd9) | (bus.d2 > 4'd9) | (bus.d3 > 4'd9) | (bus.d4 > 4'd9);
  // ripple borrow: a zero digit wraps to 9 and passes the borrow up, a non-zero digit absorbs it
  always_comb begin
    borrow = 1'b1;
    dec = cnt;
    for (int i = 0; i < 4; i++) begin
      dec[i] = borrow ? ((cnt[i] == 4'd0) ? 4'd9 : cnt[i] - 4'd1) : cnt[i];
      borrow = borrow & (cnt[i] == 4'd0);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shadow_n = shadow;
    err_n = err_q;
    if (bus.abort) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE, LOADED: begin
          if (bus.load) begin
            cnt_n = bad ? '0 : din;
            shadow_n = bad ? '0 : din;
            err_n = bad;
            state_n = bad ? IDLE : LOADED;
          end else if (bus.start && state == LOADED) begin
            state_n = RUN;
          end
        end
        // zero is detected on the registered count, so a tick at 0000 is simply ignored
        RUN: begin
          state_n = (cnt == '0) ? DONE : RUN;
          cnt_n = (cnt != '0 && bus.tick) ? dec : cnt;
        end
        DONE: begin
          state_n = AUTO_RELOAD ? RUN : IDLE;
          cnt_n = AUTO_RELOAD ? shadow : cnt;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      err_q <= err_n;
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end
  assign bus.qq1 = cnt[0];
  assign bus.qq2 = cnt[1];
  assign bus.qq3 = cnt[2];
  assign bus.qq4 = cnt[3];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.error_bad_bcd = err_q;
endmodule
